// File: rtl/gpio_avm_sequencer_pkg.sv
// rtl/gpio_avm_sequencer_pkg.sv - shared types and constants for the GPIO Avalon-MM sequencer
// Purpose: sequencer state encoding, GPIO slave register map and the expected slave ID.
// Ports: none (package).
package gpio_avm_pkg;

  typedef enum logic [2:0] {
    PRB0 = 3'd0,
    PRB1 = 3'd1,
    IDLE = 3'd2,
    REQ  = 3'd3,
    LAT  = 3'd4,
    RSP  = 3'd5
  } state_t;

  // GPIO slave word addresses
  localparam logic [4:0] ADDR_WIDTH  = 5'd0;
  localparam logic [4:0] ADDR_ID     = 5'd1;
  localparam logic [4:0] ADDR_OE     = 5'd2;
  localparam logic [4:0] ADDR_IN     = 5'd3;
  localparam logic [4:0] ADDR_BIT_LO = 5'd4;
  localparam logic [4:0] ADDR_BIT_HI = 5'd5;

  localparam logic [31:0] GPIO_ID = 32'hEA680001;

endpackage

// File: rtl/gpio_avm_sequencer_if.sv
// rtl/gpio_avm_sequencer_if.sv - command/response and Avalon-MM signal bundle
// Purpose: groups the host command/response handshake and the Avalon-MM master bus.
// Ports (modport master = sequencer side, slave = host + GPIO slave side):
//   cmd_valid/cmd_ready/cmd_write/cmd_address/cmd_writedata/cmd_byteenable - host command
//   rsp_valid/rsp_data/rsp_error - response pulse and held result
//   avm_address/avm_read/avm_write/avm_writedata/avm_byteenable/avm_readdata/avm_waitrequest - bus
interface gpio_avm_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [4:0]  cmd_address;
  logic [31:0] cmd_writedata;
  logic [3:0]  cmd_byteenable;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_error;
  logic [4:0]  avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    input  cmd_valid, cmd_write, cmd_address, cmd_writedata, cmd_byteenable,
    output cmd_ready, rsp_valid, rsp_data, rsp_error,
    output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_address, cmd_writedata, cmd_byteenable,
    input  cmd_ready, rsp_valid, rsp_data, rsp_error,
    input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    output avm_readdata, avm_waitrequest
  );
endinterface

// File: rtl/gpio_avm_sequencer_timer.sv
// rtl/gpio_avm_sequencer_timer.sv - stall timeout and read latency counters
// Purpose: counts waitrequest stalls of the active request and cycles spent waiting for read data.
// Ports:
//   csi_MCLK_clk, rsi_MRST_reset - clock, async active-high reset
//   i_req          - a bus request is currently asserted
//   i_waitrequest  - slave stall
//   i_lat_run      - sequencer is waiting for read data
//   o_timeout      - this stalled cycle is the last one allowed; drop the request
//   o_lat_done     - read data is valid this cycle
module avm_req_timer #(
  parameter int READ_LATENCY = 1,
  parameter int TIMEOUT      = 255
) (
  input  logic csi_MCLK_clk,
  input  logic rsi_MRST_reset,
  input  logic i_req,
  input  logic i_waitrequest,
  input  logic i_lat_run,
  output logic o_timeout,
  output logic o_lat_done
);

  localparam logic [7:0] STALL_LAST = 8'(TIMEOUT - 1);
  localparam logic [1:0] LAT_LAST   = 2'(READ_LATENCY - 1);

  logic [7:0] r_stall_cnt;
  logic [1:0] r_lat_cnt;

  // Timeout fires during the TIMEOUT-th stalled cycle so the request is held exactly TIMEOUT cycles.
  assign o_timeout  = i_req && i_waitrequest && (r_stall_cnt == STALL_LAST);
  assign o_lat_done = i_lat_run && (r_lat_cnt == LAT_LAST);

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      r_stall_cnt <= 8'd0;
      r_lat_cnt   <= 2'd0;
    end else begin
      if (!i_req || !i_waitrequest || o_timeout) r_stall_cnt <= 8'd0;
      else                                       r_stall_cnt <= r_stall_cnt + 8'd1;
      if (!i_lat_run || o_lat_done) r_lat_cnt <= 2'd0;
      else                          r_lat_cnt <= r_lat_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/gpio_avm_sequencer.sv
// rtl/gpio_avm_sequencer.sv - Avalon-MM master that probes and drives one GPIO slave
// Purpose: reads the slave width/ID registers after reset, then runs host commands as single
//          Avalon reads/writes with waitrequest, fixed read latency and stall timeout.
// Ports:
//   csi_MCLK_clk, rsi_MRST_reset - clock, async active-high reset
//   bus        - command/response handshake and Avalon-MM master (master modport)
//   probe_done - probe sequence finished (sticky)
//   probe_ok   - slave ID matched EXPECT_ID (sticky)
//   port_width - low byte of slave address 0
module gpio_avm_sequencer
  import gpio_avm_pkg::*;
#(
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] EXPECT_ID    = GPIO_ID,
  parameter int          TIMEOUT      = 255
) (
  input  logic                        csi_MCLK_clk,
  input  logic                        rsi_MRST_reset,
  gpio_avm_sequencer_if.master        bus,
  output logic                        probe_done,
  output logic                        probe_ok,
  output logic [7:0]                  port_width
);

  state_t      r_state, w_state;
  logic        r_avm_read, w_avm_read;
  logic        r_avm_write, w_avm_write;
  logic [4:0]  r_addr, w_addr;
  logic [31:0] r_wdata, w_wdata;
  logic [3:0]  r_be, w_be;
  logic [31:0] r_rsp_data, w_rsp_data;
  logic        r_rsp_error, w_rsp_error;
  logic        r_probe_done, w_probe_done;
  logic        r_probe_ok, w_probe_ok;
  logic [7:0]  r_port_width, w_port_width;

  logic w_req, w_accept, w_timeout, w_lat_done, w_cmd_ready;

  assign w_req       = r_avm_read | r_avm_write;
  assign w_accept    = w_req & ~bus.avm_waitrequest;
  assign w_cmd_ready = (r_state == IDLE) & r_probe_done;

  avm_req_timer #(
    .READ_LATENCY(READ_LATENCY),
    .TIMEOUT     (TIMEOUT)
  ) u_timer (
    .csi_MCLK_clk  (csi_MCLK_clk),
    .rsi_MRST_reset(rsi_MRST_reset),
    .i_req         (w_req),
    .i_waitrequest (bus.avm_waitrequest),
    .i_lat_run     (r_state == LAT),
    .o_timeout     (w_timeout),
    .o_lat_done    (w_lat_done)
  );

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      r_state      <= PRB0;
      r_avm_read   <= 1'b0;
      r_avm_write  <= 1'b0;
      r_addr       <= 5'd0;
      r_wdata      <= 32'd0;
      r_be         <= 4'd0;
      r_rsp_data   <= 32'd0;
      r_rsp_error  <= 1'b0;
      r_probe_done <= 1'b0;
      r_probe_ok   <= 1'b0;
      r_port_width <= 8'd0;
    end else begin
      r_state      <= w_state;
      r_avm_read   <= w_avm_read;
      r_avm_write  <= w_avm_write;
      r_addr       <= w_addr;
      r_wdata      <= w_wdata;
      r_be         <= w_be;
      r_rsp_data   <= w_rsp_data;
      r_rsp_error  <= w_rsp_error;
      r_probe_done <= w_probe_done;
      r_probe_ok   <= w_probe_ok;
      r_port_width <= w_port_width;
    end
  end

  // Bus request flags are registered and raised on entry to a request state, so every
  // output is a flop (or a decode of flops) and reset drops the bus immediately.
  always_comb begin
    w_state      = r_state;
    w_avm_read   = r_avm_read;
    w_avm_write  = r_avm_write;
    w_addr       = r_addr;
    w_wdata      = r_wdata;
    w_be         = r_be;
    w_rsp_data   = r_rsp_data;
    w_rsp_error  = r_rsp_error;
    w_probe_done = r_probe_done;
    w_probe_ok   = r_probe_ok;
    w_port_width = r_port_width;
    case (r_state)
      PRB0, PRB1: begin
        if (!r_avm_read) begin
          // first cycle in a probe state launches the read
          w_avm_read = 1'b1;
          w_addr     = (r_state == PRB0) ? ADDR_WIDTH : ADDR_ID;
          w_be       = 4'hF;
        end else if (w_accept) begin
          w_avm_read = 1'b0;
          w_state    = LAT;
        end else if (w_timeout) begin
          w_avm_read   = 1'b0;
          w_probe_done = 1'b1;
          w_probe_ok   = 1'b0;
          w_state      = IDLE;
        end
      end
      IDLE: begin
        if (bus.cmd_valid && w_cmd_ready) begin
          w_addr      = bus.cmd_address;
          w_wdata     = bus.cmd_writedata;
          w_be        = bus.cmd_write ? bus.cmd_byteenable : 4'hF;
          // a failed probe leaves the bus untouched; REQ then answers with an error
          w_avm_read  = r_probe_ok & ~bus.cmd_write;
          w_avm_write = r_probe_ok & bus.cmd_write;
          w_state     = REQ;
        end
      end
      REQ: begin
        if (!r_probe_ok) begin
          w_rsp_data  = 32'd0;
          w_rsp_error = 1'b1;
          w_state     = RSP;
        end else if (w_accept) begin
          w_avm_read  = 1'b0;
          w_avm_write = 1'b0;
          if (r_avm_write) begin
            w_rsp_data  = 32'd0;
            w_rsp_error = 1'b0;
            w_state     = RSP;
          end else begin
            w_state = LAT;
          end
        end else if (w_timeout) begin
          w_avm_read  = 1'b0;
          w_avm_write = 1'b0;
          w_rsp_data  = 32'd0;
          w_rsp_error = 1'b1;
          w_state     = RSP;
        end
      end
      LAT: begin
        if (w_lat_done) begin
          if (r_probe_done) begin
            w_rsp_data  = bus.avm_readdata;
            w_rsp_error = 1'b0;
            w_state     = RSP;
          end else if (r_addr == ADDR_WIDTH) begin
            w_port_width = bus.avm_readdata[7:0];
            w_state      = PRB1;
          end else begin
            w_probe_ok   = (bus.avm_readdata == EXPECT_ID);
            w_probe_done = 1'b1;
            w_state      = IDLE;
          end
        end
      end
      RSP:     w_state = IDLE;
      default: w_state = PRB0;
    endcase
  end

  assign bus.cmd_ready      = w_cmd_ready;
  assign bus.rsp_valid      = (r_state == RSP);
  assign bus.rsp_data       = r_rsp_data;
  assign bus.rsp_error      = r_rsp_error;
  assign bus.avm_address    = r_addr;
  assign bus.avm_read       = r_avm_read;
  assign bus.avm_write      = r_avm_write;
  assign bus.avm_writedata  = r_wdata;
  assign bus.avm_byteenable = r_be;
  assign probe_done         = r_probe_done;
  assign probe_ok           = r_probe_ok;
  assign port_width         = r_port_width;

endmodule

// File: tb/tb_gpio_avm_sequencer.sv
// tb/tb_gpio_avm_sequencer.sv - directed self-checking bench for gpio_avm_sequencer
module tb_gpio_avm_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       probe_done;
  logic       probe_ok;
  logic [7:0] port_width;

  gpio_avm_sequencer_if bus();

  gpio_avm_sequencer #(
    .READ_LATENCY(2),
    .EXPECT_ID   (32'hEA680001),
    .TIMEOUT     (8)
  ) dut (
    .csi_MCLK_clk  (clk),
    .rsi_MRST_reset(rst),
    .bus           (bus),
    .probe_done    (probe_done),
    .probe_ok      (probe_ok),
    .port_width    (port_width)
  );

  always #5 clk = ~clk;

  // GPIO slave model: registered read data valid in the 2nd cycle after acceptance, garbage otherwise
  logic [31:0] mem [0:31];
  logic        s_pvalid;
  logic [31:0] s_pdata;
  always @(posedge clk) begin
    s_pvalid         <= bus.avm_read && !bus.avm_waitrequest;
    s_pdata          <= mem[bus.avm_address];
    bus.avm_readdata <= s_pvalid ? s_pdata : 32'hDEADBEEF;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int n_rd, n_wr, n_rsp, n_bad, n_both, n_rdy_busy, rsp_at, cyc_idx, stall_left;
  logic        stuck;
  logic [4:0]  first_addr;
  logic [4:0]  exp_addr;
  logic [31:0] exp_wdata;
  logic [3:0]  exp_be;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: sample at the falling edge, then update the waitrequest stimulus
  task automatic cyc();
    @(negedge clk);
    cyc_idx++;
    if (bus.avm_read) begin
      if (n_rd == 0) first_addr = bus.avm_address;
      n_rd++;
      if (bus.avm_address !== exp_addr || bus.avm_byteenable !== 4'hF) n_bad++;
    end
    if (bus.avm_write) begin
      n_wr++;
      if (bus.avm_address !== exp_addr || bus.avm_writedata !== exp_wdata ||
          bus.avm_byteenable !== exp_be) n_bad++;
    end
    if (bus.avm_read && bus.avm_write) n_both++;
    if (bus.rsp_valid) begin
      n_rsp++;
      if (rsp_at == 0) rsp_at = cyc_idx;
    end
    if (bus.cmd_ready && rsp_at == 0) n_rdy_busy++;
    bus.avm_waitrequest = stuck || ((bus.avm_read || bus.avm_write) && stall_left > 0);
    if (!stuck && bus.avm_waitrequest) stall_left--;
  endtask

  task automatic clear_counts();
    n_rd = 0; n_wr = 0; n_rsp = 0; n_bad = 0; n_rdy_busy = 0; rsp_at = 0; cyc_idx = 0;
  endtask

  task automatic run_cmd(input logic wr, input logic [4:0] a, input logic [31:0] d,
                         input logic [3:0] be, input int stall, input logic stk);
    clear_counts();
    exp_addr = a; exp_wdata = d; exp_be = wr ? be : 4'hF;
    stall_left = stall; stuck = stk;
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_address = a;
    bus.cmd_writedata = d; bus.cmd_byteenable = be;
    cyc();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 30 && rsp_at == 0; i++) cyc();
    stuck = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic wait_probe();
    for (int i = 0; i < 60 && probe_done !== 1'b1; i++) cyc();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'hC0DE0000 | 32'(i);
    mem[0] = 32'd128;
    mem[1] = 32'hEA680001;
    mem[3] = 32'h000000A5;
    rst = 1'b1; stuck = 1'b0; stall_left = 0; n_both = 0;
    exp_addr = 5'd0; exp_wdata = 32'd0; exp_be = 4'hF; first_addr = 5'd31;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_address = 5'd0;
    bus.cmd_writedata = 32'd0; bus.cmd_byteenable = 4'd0; bus.avm_waitrequest = 1'b0;
    clear_counts();
    repeat (3) cyc();

    // reset state
    chk("rst_avm_read", bus.avm_read, 0);
    chk("rst_avm_write", bus.avm_write, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_probe_done", probe_done, 0);
    chk("rst_probe_ok", probe_ok, 0);
    chk("rst_port_width", port_width, 0);

    // probe OK
    clear_counts();
    rst = 1'b0;
    wait_probe();
    chk("probe_done", probe_done, 1);
    chk("probe_ok", probe_ok, 1);
    chk("port_width", port_width, 8'h80);
    chk("probe_reads", n_rd, 2);
    chk("probe_first_addr", first_addr, 0);
    chk("probe_cmd_ready", bus.cmd_ready, 1);

    // read with READ_LATENCY=2: REQ, LAT, LAT, RSP
    run_cmd(1'b0, 5'd3, 32'd0, 4'h0, 0, 1'b0);
    chk("rd_latency", rsp_at, 4);
    chk("rd_data", bus.rsp_data, 32'h000000A5);
    chk("rd_error", bus.rsp_error, 0);
    chk("rd_pulses", n_rsp, 1);
    chk("rd_bus_cycles", n_rd, 1);
    chk("rd_fields", n_bad, 0);
    chk("rd_busy_ready", n_rdy_busy, 0);

    // write held through 3 stalled cycles
    run_cmd(1'b1, 5'd4, 32'h01000001, 4'b1001, 3, 1'b0);
    chk("wr_stall_cycles", n_wr, 4);
    chk("wr_stall_fields", n_bad, 0);
    chk("wr_stall_latency", rsp_at, 5);
    chk("wr_stall_pulses", n_rsp, 1);
    chk("wr_stall_error", bus.rsp_error, 0);
    chk("wr_stall_data", bus.rsp_data, 0);

    // unstalled write: response 2 cycles after handshake
    run_cmd(1'b1, 5'd5, 32'hA5A55A5A, 4'b0110, 0, 1'b0);
    chk("wr_latency", rsp_at, 2);
    chk("wr_cycles", n_wr, 1);
    chk("wr_fields", n_bad, 0);

    // timeout: request dropped after 8 stalled cycles
    run_cmd(1'b0, 5'd2, 32'd0, 4'h0, 0, 1'b1);
    chk("to_req_cycles", n_rd, 8);
    chk("to_latency", rsp_at, 9);
    chk("to_error", bus.rsp_error, 1);
    chk("to_data", bus.rsp_data, 0);
    chk("to_pulses", n_rsp, 1);
    chk("to_cmd_ready", bus.cmd_ready, 1);

    // reset during LAT of a read
    clear_counts();
    exp_addr = 5'd3;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_address = 5'd3;
    cyc();
    bus.cmd_valid = 1'b0;
    cyc();
    rst = 1'b1;
    #1;
    chk("mid_rst_avm_read", bus.avm_read, 0);
    chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
    chk("mid_rst_probe_done", probe_done, 0);
    chk("mid_rst_probe_ok", probe_ok, 0);
    chk("mid_rst_port_width", port_width, 0);

    // re-probe with a wrong ID
    mem[1] = 32'h12345678;
    repeat (2) cyc();
    clear_counts();
    rst = 1'b0;
    wait_probe();
    chk("bad_first_addr", first_addr, 0);
    chk("bad_probe_done", probe_done, 1);
    chk("bad_probe_ok", probe_ok, 0);
    chk("bad_port_width", port_width, 8'h80);

    // command after failed probe: error response, no bus access
    run_cmd(1'b0, 5'd3, 32'd0, 4'h0, 0, 1'b0);
    chk("bad_rd_bus_cycles", n_rd, 0);
    chk("bad_rd_latency", rsp_at, 2);
    chk("bad_rd_error", bus.rsp_error, 1);
    chk("bad_rd_data", bus.rsp_data, 0);
    chk("never_rd_and_wr", n_both, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
